wb_initiator: RTL and testbench

//  Wishbone classic initiator: the bus-master end of the wbs_* responder interface on the TMS1x00 wrapper.

---
 rtl/wbi_pkg.sv | 21 ++
 rtl/wbi_cmd_fifo.sv | 41 ++++
 rtl/wb_initiator.sv | 136 +++++++++++++
 tb/tb_wb_initiator.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbi_pkg.sv
// rtl/wbi_pkg.sv - shared types and sizing helper for the Wishbone initiator
package wbi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } wbi_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wbi_cmd_t;

    function automatic int to_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wbi_cmd_fifo.sv
// rtl/wbi_cmd_fifo.sv - synchronous command FIFO, head visible on dout while non-empty
module wbi_cmd_fifo
    import wbi_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  wbi_cmd_t din,
    input  logic     pop,
    output wbi_cmd_t dout,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    wbi_cmd_t        mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - Wishbone classic initiator: one single-beat cycle per queued command
module wb_initiator
    import wbi_pkg::*;
#(
    parameter int CMD_DEPTH      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);
    localparam int            TW      = to_w(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    wbi_state_e    state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    wbi_cmd_t      cmd_in, head, bus_q, bus_d;
    logic          cyc_q, cyc_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;
    logic          push, pop, full, empty;

    assign cmd_in = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
    assign push   = cmd_valid && !full;

    wbi_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (push),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_q       <= '0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_q       <= bus_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_d       = bus_q;
        cyc_d       = cyc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    bus_d   = head;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // An ack on the final allowed cycle still completes normally.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = bus_q.we ? 32'h0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == TO_LAST) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = 32'h0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = !full;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = bus_q.we;
    assign wbm_adr_o = bus_q.adr;
    assign wbm_dat_o = bus_q.dat;
    assign wbm_sel_o = bus_q.sel;
    assign busy      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - randomized self-checking bench for wb_initiator against a transaction-level model
module tb_wb_initiator;
    localparam int TC = 8;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          delay;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_len;
    } txn_t;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int outstanding = 0;
    int n_push = 0;
    int n_rsp = 0;
    int rsp_mode = 0;
    int stray_mode = 0;

    txn_t        pend_q[$];
    txn_t        rsp_q[$];
    int          plan_q[$];
    logic [31:0] log_dat[$];
    logic        log_err[$];
    int          log_len[$];
    logic [31:0] ref_mem [4];
    logic [31:0] sram [4];

    wb_initiator #(.CMD_DEPTH(2), .TIMEOUT_CYCLES(TC)) dut (
        .wb_clk_i (clk),       .wb_rst_i (rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr  (cmd_adr),   .cmd_dat  (cmd_dat),   .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int delay);
        txn_t t;
        int   guard;
        guard = 0;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            chk("push_accept", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        t.we = we; t.adr = adr; t.dat = dat; t.sel = sel; t.delay = delay;
        t.exp_err = (delay > TC - 1);
        t.exp_len = t.exp_err ? TC : delay + 1;
        if (t.exp_err) t.exp_dat = 32'h0;
        else if (we) begin
            ref_mem[adr[3:2]] = merge(ref_mem[adr[3:2]], dat, sel);
            t.exp_dat = 32'h0;
        end else t.exp_dat = ref_mem[adr[3:2]];
        pend_q.push_back(t);
        plan_q.push_back(delay);
        outstanding++;
        n_push++;
    endtask

    task automatic wait_rsp(input int target);
        int guard;
        guard = 0;
        while (n_rsp < target && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (n_rsp < target) chk("rsp_wait", n_rsp, target);
        @(posedge clk); #1;
    endtask

    task automatic chk_log(input int idx, input logic [31:0] d, input logic e, input int len);
        if (log_dat.size() <= idx || log_len.size() <= idx) begin
            chk("log_present", log_dat.size(), idx + 1);
        end else begin
            chk("lit_rsp_dat", log_dat[idx], d);
            chk("lit_rsp_err", log_err[idx], e);
            chk("lit_cyc_len", log_len[idx], len);
        end
    endtask

    // Wishbone responder: acks after the planned number of wait cycles, backed by its own SRAM.
    initial begin
        logic [1:0] ridx;
        int         r_wait, r_delay;
        bit         r_active;
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0; r_active = 0; r_wait = 0; r_delay = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                r_active  = 0;
                wbm_ack_i = 1'b0;
            end else if (wbm_cyc_o) begin
                if (!r_active) begin
                    r_active = 1;
                    r_wait   = 0;
                    r_delay  = (plan_q.size() != 0) ? plan_q.pop_front() : 1000;
                end
                if (r_wait == r_delay) begin
                    wbm_ack_i = 1'b1;
                    ridx = wbm_adr_o[3:2];
                    if (wbm_we_o) begin
                        sram[ridx] = merge(sram[ridx], wbm_dat_o, wbm_sel_o);
                        wbm_dat_i  = $urandom;
                    end else wbm_dat_i = sram[ridx];
                end else begin
                    wbm_ack_i = 1'b0;
                    wbm_dat_i = $urandom;
                end
                r_wait++;
            end else begin
                r_active  = 0;
                wbm_ack_i = (stray_mode == 2) || (stray_mode == 1 && $urandom_range(0, 3) == 0);
                wbm_dat_i = $urandom;
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Per-cycle compare against the transaction model.
    initial begin
        txn_t t, cur;
        bit   cyc_prev, cur_valid;
        int   cyc_len;
        cyc_prev = 0; cur_valid = 0; cyc_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc_prev  = 0;
                cur_valid = 0;
            end else begin
                chk("stb_eq_cyc", wbm_stb_o, wbm_cyc_o);
                if (wbm_cyc_o && !cyc_prev) begin
                    chk("cmd_pending", pend_q.size() != 0, 1);
                    if (pend_q.size() != 0) begin
                        cur       = pend_q.pop_front();
                        cur_valid = 1;
                        cyc_len   = 0;
                    end
                end
                if (wbm_cyc_o) cyc_len++;
                if (cur_valid) begin
                    chk("wbm_we", wbm_we_o, cur.we);
                    chk("wbm_adr", wbm_adr_o, cur.adr);
                    chk("wbm_dat", wbm_dat_o, cur.dat);
                    chk("wbm_sel", wbm_sel_o, cur.sel);
                end
                if (!wbm_cyc_o && cyc_prev && cur_valid) begin
                    chk("cyc_len", cyc_len, cur.exp_len);
                    log_len.push_back(cyc_len);
                    rsp_q.push_back(cur);
                end
                chk("cmd_ready", cmd_ready, pend_q.size() < 2);
                chk("busy", busy, outstanding != 0);
                if (rsp_valid) begin
                    chk("rsp_pending", rsp_q.size() != 0, 1);
                    if (rsp_q.size() != 0) begin
                        chk("rsp_dat", rsp_dat, rsp_q[0].exp_dat);
                        chk("rsp_err", rsp_err, rsp_q[0].exp_err);
                        if (rsp_ready) begin
                            t = rsp_q.pop_front();
                            log_dat.push_back(rsp_dat);
                            log_err.push_back(rsp_err);
                            outstanding--;
                            n_rsp++;
                        end
                    end
                end
                cyc_prev = wbm_cyc_o;
            end
        end
    end

    initial begin
        int base, guard;
        for (int i = 0; i < 4; i++) begin
            ref_mem[i] = 32'h1111_1111 * (i + 1);
            sram[i]    = 32'h1111_1111 * (i + 1);
        end
        ref_mem[1] = 32'hA5A5_A5A5;
        sram[1]    = 32'hA5A5_A5A5;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        base = n_rsp;
        push(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 2);
        wait_rsp(base + 1);
        chk_log(base, 32'h0, 1'b0, 3);

        base = n_rsp;
        push(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0);
        chk("lat_cyc_k", wbm_cyc_o, 0);
        @(posedge clk); #1;
        chk("lat_cyc_k1", wbm_cyc_o, 1);
        chk("lat_rsp_k1", rsp_valid, 0);
        @(posedge clk); #1;
        chk("lat_cyc_k2", wbm_cyc_o, 0);
        chk("lat_rsp_k2", rsp_valid, 1);
        wait_rsp(base + 1);
        chk_log(base, 32'hDEAD_BEEF, 1'b0, 1);

        base = n_rsp;
        push(1'b0, 32'h3000_0004, 32'h0, 4'hF, 99);
        push(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1);
        wait_rsp(base + 2);
        chk_log(base, 32'h0, 1'b1, 8);
        chk_log(base + 1, 32'hA5A5_A5A5, 1'b0, 2);

        base = n_rsp;
        push(1'b1, 32'h3000_0008, 32'h0BAD_F00D, 4'hF, 7);
        wait_rsp(base + 1);
        chk_log(base, 32'h0, 1'b0, 8);

        base = n_rsp;
        stray_mode = 2;
        repeat (20) @(posedge clk);
        #1;
        stray_mode = 0;
        chk("stray_rsp_valid", rsp_valid, 0);
        chk("stray_busy", busy, 0);
        chk("stray_no_rsp", n_rsp, base);

        base = n_rsp;
        rsp_mode = 2;
        push(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0);
        push(1'b1, 32'h3000_0004, 32'h1234_5678, 4'b0011, 1);
        push(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0);
        chk("full_cmd_ready", cmd_ready, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("full_hold", cmd_ready, 0);
        chk("full_rsp_valid", rsp_valid, 1);
        rsp_mode = 0;
        push(1'b1, 32'h3000_000C, 32'hCAFE_0000, 4'b1100, 0);
        wait_rsp(base + 4);
        chk_log(base, 32'hDEAD_BEEF, 1'b0, 1);
        chk_log(base + 1, 32'h0, 1'b0, 2);
        chk_log(base + 2, 32'hA5A5_5678, 1'b0, 1);

        base = n_rsp;
        push(1'b0, 32'h3000_0008, 32'h0, 4'hF, 99);
        push(1'b0, 32'h3000_0008, 32'h0, 4'hF, 0);
        guard = 0;
        while (!wbm_cyc_o && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("rst_test_cyc", wbm_cyc_o, 1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_cyc", wbm_cyc_o, 0);
        chk("rst_mid_stb", wbm_stb_o, 0);
        chk("rst_mid_busy", busy, 0);
        pend_q.delete(); rsp_q.delete(); plan_q.delete();
        outstanding = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_rel_ready", cmd_ready, 1);
        repeat (15) @(posedge clk);
        #1;
        chk("rst_no_rsp", n_rsp, base);
        chk("rst_rsp_valid", rsp_valid, 0);
        push(1'b0, 32'h3000_0008, 32'h0, 4'hF, 3);
        wait_rsp(base + 1);
        chk_log(base, 32'h0BAD_F00D, 1'b0, 4);

        rsp_mode = 1;
        stray_mode = 1;
        for (int i = 0; i < 60; i++) begin
            push(1'($urandom_range(0, 1)), 32'h3000_0000 + 32'(4 * $urandom_range(0, 3)),
                 $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 9)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rsp_mode = 0;
        stray_mode = 0;
        guard = 0;
        while (outstanding != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", outstanding, 0);
        chk("rsp_total", n_rsp, n_push - 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
